// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter in front of one iterative shift-add unsigned multiplier.
// One job in flight at a time; product and owner id come back on a single
// valid/ready response port.
module mul_share_arbiter #(
  parameter  int NREQ  = 2,
  parameter  int WIDTH = 4,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [2*WIDTH-1:0]      rsp_product,
  output logic [IDW-1:0]          rsp_id,
  output logic                    busy
);

  localparam int          CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned NR = NREQ;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     grant;
  logic               grant_vld;
  logic [IDW-1:0]     id_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] a_ext;
  logic [CW-1:0]      cnt;
  logic               accept;
  logic               last_step;
  int unsigned        sel;

  // Round-robin search: first valid requester starting just above ptr, wrapping.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    sel       = 0;
    for (int unsigned k = 1; k <= NR; k++) begin
      sel = (32'(ptr) + k) % NR;
      if (!grant_vld && req_valid[sel[IDW-1:0]]) begin
        grant_vld = 1'b1;
        grant     = sel[IDW-1:0];
      end
    end
  end

  // One-hot ready toward the granted requester, only in IDLE and never in reset.
  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && grant_vld) begin
      req_ready = NREQ'(1) << grant;
    end
  end

  assign accept    = |(req_valid & req_ready);
  assign last_step = (cnt == CW'(WIDTH - 1));
  assign a_ext     = {{WIDTH{1'b0}}, a_q};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept)    state_nx = CALC;
      CALC: if (last_step) state_nx = DONE;
      DONE: if (rsp_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  // Job capture on handshake, then one shift-add step per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr  <= IDW'(NREQ - 1);
      id_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else if (accept) begin
      a_q  <= req_a[grant*WIDTH +: WIDTH];
      b_q  <= req_b[grant*WIDTH +: WIDTH];
      id_q <= grant;
      ptr  <= grant;
      acc  <= '0;
      cnt  <= '0;
    end else if (state == CALC) begin
      if (b_q[cnt]) begin
        acc <= acc + (a_ext << cnt);
      end
      cnt <= cnt + 1'b1;
    end
  end

  assign rsp_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign rsp_product = acc;
  assign rsp_id      = id_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter (NREQ=2, WIDTH=4).
module tb_mul_share_arbiter;

  localparam int NREQ  = 2;
  localparam int WIDTH = 4;
  localparam int IDW   = 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2*WIDTH-1:0]    rsp_product;
  logic [IDW-1:0]        rsp_id;
  logic                  busy;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  mul_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .rsp_id      (rsp_id),
    .busy        (busy)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Free-running cycle counter used to measure job spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [3:0] a0, input logic [3:0] b0,
                         input logic [3:0] a1, input logic [3:0] b1);
    req_valid = v;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    #1;
  endtask

  // Accept one job, scramble the operands during CALC, wait bounded for rsp_valid.
  task automatic do_job(input logic [1:0] exp_ready, input logic [7:0] exp_prod,
                        input logic exp_id, output int done_cyc);
    logic [NREQ*WIDTH-1:0] sa;
    logic [NREQ*WIDTH-1:0] sb;
    int lat;
    check("grant_ready", req_ready, exp_ready);
    tick();
    check("busy_after_accept", busy, 1);
    check("ready_in_calc", req_ready, 0);
    sa = req_a;
    sb = req_b;
    req_a = ~req_a;
    req_b = ~req_b;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, 4);
    check("product", rsp_product, exp_prod);
    check("rsp_id", rsp_id, exp_id);
    done_cyc = cyc;
    req_a = sa;
    req_b = sb;
    #1;
  endtask

  initial begin
    int c_prev;
    int c_now;
    logic [3:0] ca [5];
    logic [3:0] cb [5];
    logic [7:0] cp [5];
    ca = '{4'd0, 4'd15, 4'd1,  4'd8,  4'd15};
    cb = '{4'd0, 4'd1,  4'd15, 4'd8,  4'd15};
    cp = '{8'd0, 8'd15, 8'd15, 8'd64, 8'd225};

    // Reset state, with requests pending to prove req_ready is forced low.
    rst       = 1'b1;
    rsp_ready = 1'b0;
    set_req(2'b11, 4'd3, 4'd4, 4'd5, 4'd6);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_product", rsp_product, 0);
    check("rst_id", rsp_id, 0);
    check("rst_busy", busy, 0);
    set_req(2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
    tick();
    tick();
    rst = 1'b0;

    // Single request 3*4.
    set_req(2'b01, 4'd3, 4'd4, 4'd0, 4'd0);
    do_job(2'b01, 8'd12, 1'b0, c_now);
    req_valid = 2'b00;
    tick();
    check("single_hold_valid", rsp_valid, 1);
    check("single_hold_busy", busy, 1);
    rsp_ready = 1'b1;
    tick();
    check("single_done_valid", rsp_valid, 0);
    check("single_done_busy", busy, 0);
    check("single_product_held", rsp_product, 12);

    // Tie right after reset: requester 0 wins, then requester 1.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    set_req(2'b11, 4'd7, 4'd5, 4'd15, 4'd15);
    do_job(2'b01, 8'd35, 1'b0, c_now);
    tick();
    do_job(2'b10, 8'd225, 1'b1, c_now);
    tick();

    // Fairness: both held valid for six jobs, rsp_ready high.
    c_prev = 0;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) do_job(2'b01, 8'd35, 1'b0, c_now);
      else            do_job(2'b10, 8'd225, 1'b1, c_now);
      if (i > 0) check("job_period", c_now - c_prev, 6);
      c_prev = c_now;
      tick();
    end

    // Backpressure: hold DONE for 10 cycles.
    rsp_ready = 1'b0;
    set_req(2'b01, 4'd7, 4'd5, 4'd15, 4'd15);
    do_job(2'b01, 8'd35, 1'b0, c_now);
    set_req(2'b11, 4'd7, 4'd5, 4'd15, 4'd15);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", rsp_valid, 1);
      check("bp_product", rsp_product, 35);
      check("bp_id", rsp_id, 0);
      check("bp_ready", req_ready, 0);
      check("bp_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release_valid", rsp_valid, 0);
    check("bp_release_busy", busy, 0);
    check("bp_next_grant", req_ready, 2'b10);
    set_req(2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
    check("idle_no_ready", req_ready, 0);

    // Reset two cycles into a 15*15 job.
    set_req(2'b01, 4'd15, 4'd15, 4'd0, 4'd0);
    check("midrst_grant", req_ready, 2'b01);
    tick();
    tick();
    tick();
    check("midrst_partial", rsp_product, 45);
    rst = 1'b1;
    set_req(2'b11, 4'd1, 4'd15, 4'd0, 4'd8);
    check("midrst_busy", busy, 0);
    check("midrst_valid", rsp_valid, 0);
    check("midrst_product", rsp_product, 0);
    check("midrst_id", rsp_id, 0);
    check("midrst_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    do_job(2'b01, 8'd15, 1'b0, c_now);
    tick();
    do_job(2'b10, 8'd0, 1'b1, c_now);
    tick();

    // Operand corners on requester 0 alone.
    for (int i = 0; i < 5; i++) begin
      set_req(2'b01, ca[i], cb[i], 4'd0, 4'd0);
      do_job(2'b01, cp[i], 1'b0, c_now);
      tick();
    end
    set_req(2'b00, 4'd0, 4'd0, 4'd0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
